// File: rtl/tournament_predictor_mp.sv
// tournament_predictor_mp: gshare + bimodal tournament direction predictor with a per-PC chooser.
// Latency: prediction is combinational from registered tables and GHR; updates take effect next cycle.
// Backpressure: none; it never stalls, and resolutions are applied even while fetch is stalled.
//
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   fetch_stall                  fetch bundle not consumed (GHR holds unless recovering)
//   fetch_pc / fetch_is_br       lane PCs (lane 0 oldest) and per-lane valid conditional branch
//   pred_taken / pred_meta       per-lane prediction and {gshare_idx, simple_idx, ghist, gshare_pred, simple_pred}
//   upd_valid/taken/mispred/meta resolution ports, port 0 oldest
//   stat_lookups/updates/mispreds  event counters, present only when BP_STATS_EN is defined (else 0)
module tournament_predictor_mp #(
   parameter int WIDTH     = 4,
   parameter int UPD_PORTS = 2,
   parameter int IDX_BITS  = 10,
   parameter int HIST_BITS = 8,
   parameter int CTR_BITS  = 2,
   localparam int META_W   = 2*IDX_BITS + HIST_BITS + 2
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        fetch_stall,
   input  logic [WIDTH*32-1:0]         fetch_pc,
   input  logic [WIDTH-1:0]            fetch_is_br,
   output logic [WIDTH-1:0]            pred_taken,
   output logic [WIDTH*META_W-1:0]     pred_meta,
   input  logic [UPD_PORTS-1:0]        upd_valid,
   input  logic [UPD_PORTS-1:0]        upd_taken,
   input  logic [UPD_PORTS-1:0]        upd_mispred,
   input  logic [UPD_PORTS*META_W-1:0] upd_meta,
   output logic [31:0]                 stat_lookups,
   output logic [31:0]                 stat_updates,
   output logic [31:0]                 stat_mispreds
);

   localparam int TBL_SIZE = 1 << IDX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS-1)) - 1);
   // meta field offsets
   localparam int GH_LSB = 2;
   localparam int SI_LSB = 2 + HIST_BITS;
   localparam int GI_LSB = 2 + HIST_BITS + IDX_BITS;

   logic [CTR_BITS-1:0]  gshare_tbl [TBL_SIZE];
   logic [CTR_BITS-1:0]  simple_tbl [TBL_SIZE];
   logic [CTR_BITS-1:0]  choose_tbl [TBL_SIZE];
   logic [HIST_BITS-1:0] ghr;
   logic [HIST_BITS-1:0] ghr_fetch_next;
   logic [WIDTH-1:0]     issued;

   function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c, input logic up);
      if (up) return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
      else    return (c == '0)      ? c : c - CTR_BITS'(1);
   endfunction

   // Only pc[IDX_BITS+1:2] indexes the tables.
   logic unused_pc;
   assign unused_pc = ^fetch_pc;

   // Lookup: each alive branch lane sees the GHR advanced by the predictions of earlier branch
   // lanes; the first predicted-taken lane ends the bundle.
   always_comb begin
      logic [HIST_BITS-1:0] lane_hist;
      logic [IDX_BITS-1:0]  s_idx, g_idx;
      logic                 s_pred, g_pred, p, alive;
      lane_hist  = ghr;
      alive      = 1'b1;
      pred_taken = '0;
      pred_meta  = '0;
      issued     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         s_idx  = fetch_pc[i*32+2 +: IDX_BITS];
         g_idx  = s_idx ^ IDX_BITS'(lane_hist);
         s_pred = simple_tbl[s_idx][CTR_BITS-1];
         g_pred = gshare_tbl[g_idx][CTR_BITS-1];
         p      = choose_tbl[s_idx][CTR_BITS-1] ? g_pred : s_pred;
         if (alive && fetch_is_br[i] && !reset) begin
            pred_taken[i]                 = p;
            pred_meta[i*META_W +: META_W] = {g_idx, s_idx, lane_hist, g_pred, s_pred};
            issued[i]                     = 1'b1;
            lane_hist                     = {lane_hist[HIST_BITS-2:0], p};
            if (p) alive = 1'b0;
         end
      end
      ghr_fetch_next = lane_hist;
   end

   // Resolution decode
   logic [IDX_BITS-1:0]  u_gidx  [UPD_PORTS];
   logic [IDX_BITS-1:0]  u_sidx  [UPD_PORTS];
   logic [HIST_BITS-1:0] u_ghist [UPD_PORTS];
   logic [UPD_PORTS-1:0] u_gp, u_sp;

   always_comb begin
      for (int p = 0; p < UPD_PORTS; p++) begin
         u_gidx[p]  = upd_meta[p*META_W + GI_LSB +: IDX_BITS];
         u_sidx[p]  = upd_meta[p*META_W + SI_LSB +: IDX_BITS];
         u_ghist[p] = upd_meta[p*META_W + GH_LSB +: HIST_BITS];
         u_gp[p]    = upd_meta[p*META_W + 1];
         u_sp[p]    = upd_meta[p*META_W];
      end
   end

   // Each port's write value replays every older-or-equal port hitting the same entry, so when
   // several ports collide the youngest write carries the full serial result.
   logic [CTR_BITS-1:0] g_new [UPD_PORTS];
   logic [CTR_BITS-1:0] s_new [UPD_PORTS];
   logic [CTR_BITS-1:0] c_new [UPD_PORTS];

   always_comb begin
      for (int p = 0; p < UPD_PORTS; p++) begin
         g_new[p] = gshare_tbl[u_gidx[p]];
         s_new[p] = simple_tbl[u_sidx[p]];
         c_new[p] = choose_tbl[u_sidx[p]];
         for (int q = 0; q <= p; q++) begin
            if (upd_valid[q] && u_gidx[q] == u_gidx[p])
               g_new[p] = sat_step(g_new[p], upd_taken[q]);
            if (upd_valid[q] && u_sidx[q] == u_sidx[p]) begin
               s_new[p] = sat_step(s_new[p], upd_taken[q]);
               if (u_gp[q] != u_sp[q])
                  c_new[p] = sat_step(c_new[p], u_gp[q] == upd_taken[q]);
            end
         end
      end
   end

   // Oldest mispredicting port rebuilds the history from its own snapshot.
   logic                 recover_vld;
   logic [HIST_BITS-1:0] recover_hist;

   always_comb begin
      recover_vld  = 1'b0;
      recover_hist = '0;
      for (int p = UPD_PORTS-1; p >= 0; p--) begin
         if (upd_valid[p] && upd_mispred[p]) begin
            recover_vld  = 1'b1;
            recover_hist = {u_ghist[p][HIST_BITS-2:0], upd_taken[p]};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < TBL_SIZE; i++) begin
            gshare_tbl[i] <= CTR_INIT;
            simple_tbl[i] <= CTR_INIT;
            choose_tbl[i] <= CTR_INIT;
         end
         ghr <= '0;
      end else begin
         for (int p = 0; p < UPD_PORTS; p++) begin
            if (upd_valid[p]) begin
               gshare_tbl[u_gidx[p]] <= g_new[p];
               simple_tbl[u_sidx[p]] <= s_new[p];
               choose_tbl[u_sidx[p]] <= c_new[p];
            end
         end
         if (recover_vld)
            ghr <= recover_hist;
         else if (!fetch_stall)
            ghr <= ghr_fetch_next;
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] lookups_q, updates_q, mispreds_q;
   logic [31:0] n_look, n_upd, n_mis;

   always_comb begin
      n_look = '0;
      n_upd  = '0;
      n_mis  = '0;
      for (int i = 0; i < WIDTH; i++)
         n_look = n_look + 32'(issued[i]);
      for (int p = 0; p < UPD_PORTS; p++) begin
         n_upd = n_upd + 32'(upd_valid[p]);
         n_mis = n_mis + 32'(upd_valid[p] & upd_mispred[p]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lookups_q  <= '0;
         updates_q  <= '0;
         mispreds_q <= '0;
      end else begin
         if (!fetch_stall)
            lookups_q <= lookups_q + n_look;
         updates_q  <= updates_q + n_upd;
         mispreds_q <= mispreds_q + n_mis;
      end
   end

   assign stat_lookups  = lookups_q;
   assign stat_updates  = updates_q;
   assign stat_mispreds = mispreds_q;
`else
   logic unused_issued;
   assign unused_issued = ^issued;
   assign stat_lookups  = '0;
   assign stat_updates  = '0;
   assign stat_mispreds = '0;
`endif

endmodule

// File: tb/tb_tournament_predictor_mp.sv
// Directed bench for tournament_predictor_mp with default parameters (META_W = 30).
module tb_tournament_predictor_mp;

   logic          clock;
   logic          reset;
   logic          fetch_stall;
   logic [127:0]  fetch_pc;
   logic [3:0]    fetch_is_br;
   logic [3:0]    pred_taken;
   logic [119:0]  pred_meta;
   logic [1:0]    upd_valid, upd_taken, upd_mispred;
   logic [59:0]   upd_meta;
   logic [31:0]   stat_lookups, stat_updates, stat_mispreds;

   int checks   = 0;
   int failures = 0;

   tournament_predictor_mp dut (
      .clock         (clock),
      .reset         (reset),
      .fetch_stall   (fetch_stall),
      .fetch_pc      (fetch_pc),
      .fetch_is_br   (fetch_is_br),
      .pred_taken    (pred_taken),
      .pred_meta     (pred_meta),
      .upd_valid     (upd_valid),
      .upd_taken     (upd_taken),
      .upd_mispred   (upd_mispred),
      .upd_meta      (upd_meta),
      .stat_lookups  (stat_lookups),
      .stat_updates  (stat_updates),
      .stat_mispreds (stat_mispreds)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [29:0] mk(input logic [9:0] g, input logic [9:0] s,
                                      input logic [7:0] h, input logic gp, input logic sp);
      return {g, s, h, gp, sp};
   endfunction

   function automatic logic [127:0] pcs(input logic [31:0] p0, input logic [31:0] p1,
                                        input logic [31:0] p2, input logic [31:0] p3);
      return {p3, p2, p1, p0};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      fetch_stall = 1'b0;
      fetch_is_br = '0;
      fetch_pc    = '0;
      upd_valid   = '0;
      upd_taken   = '0;
      upd_mispred = '0;
      upd_meta    = '0;
   endtask

   task automatic set_upd(input int p, input logic [29:0] m, input logic t, input logic mp);
      upd_valid[p]          = 1'b1;
      upd_taken[p]          = t;
      upd_mispred[p]        = mp;
      upd_meta[p*30 +: 30]  = m;
   endtask

   task automatic lookup1(input logic [31:0] pc);
      clr();
      fetch_stall = 1'b1;
      fetch_is_br = 4'b0001;
      fetch_pc    = pcs(pc, 32'h0, 32'h0, 32'h0);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [31:0] exp_lk, exp_up, exp_mp;

   initial begin
      clr();
      reset = 1'b1;
      // Activity during reset must be ignored.
      fetch_is_br = 4'hF;
      fetch_pc    = pcs(32'h100, 32'h100, 32'h200, 32'h300);
      set_upd(0, mk(10'h040, 10'h040, 8'hFF, 1'b0, 1'b0), 1'b1, 1'b1);
      tick();
      tick();
      chk("rst_pred_taken", 128'(pred_taken), 128'h0);
      chk("rst_pred_meta",  128'(pred_meta),  128'h0);

      // Test 1: fresh tables, pc 0x100 -> idx 0x40, weak not-taken everywhere.
      reset = 1'b0;
      lookup1(32'h100);
      chk("rst_stat_lookups",  128'(stat_lookups),  128'h0);
      chk("rst_stat_updates",  128'(stat_updates),  128'h0);
      chk("rst_stat_mispreds", 128'(stat_mispreds), 128'h0);
      chk("t1_pred", 128'(pred_taken), 128'h0);
      chk("t1_meta", 128'(pred_meta), 128'({90'b0, mk(10'h040, 10'h040, 8'h00, 1'b0, 1'b0)}));
      tick();

      // Test 2: two taken resolves on 0x100 -> simple and gshare both 11.
      clr();
      set_upd(0, mk(10'h040, 10'h040, 8'h00, 1'b0, 1'b0), 1'b1, 1'b0);
      tick();
      tick();
      lookup1(32'h100);
      chk("t2_pred", 128'(pred_taken), 128'h1);
      chk("t2_meta", 128'(pred_meta), 128'({90'b0, mk(10'h040, 10'h040, 8'h00, 1'b1, 1'b1)}));
      tick();

      // Test 3: lane 1 predicted taken; lane 2 (also 0x100) must be suppressed.
      clr();
      fetch_is_br = 4'b1111;
      fetch_pc    = pcs(32'h200, 32'h100, 32'h100, 32'h104);
      #1;
      chk("t3_pred", 128'(pred_taken), 128'h2);
      chk("t3_meta", 128'(pred_meta), 128'({60'b0, mk(10'h040, 10'h040, 8'h00, 1'b1, 1'b1),
                                                   mk(10'h080, 10'h080, 8'h00, 1'b0, 1'b0)}));
      tick();

      // GHR now 0x01; stalled lookups must hold it.
      lookup1(32'h200);
      chk("t3_ghr",      128'(pred_meta), 128'({90'b0, mk(10'h081, 10'h080, 8'h01, 1'b0, 1'b0)}));
      tick();
      chk("t3_ghr_hold", 128'(pred_meta), 128'({90'b0, mk(10'h081, 10'h080, 8'h01, 1'b0, 1'b0)}));
      tick();

      // Test 4: mispredict recovery beats a non-stalled fetch shift: A5 -> 4B.
      clr();
      fetch_is_br = 4'b0001;
      fetch_pc    = pcs(32'h200, 32'h0, 32'h0, 32'h0);
      set_upd(0, mk(10'h1F0, 10'h1F0, 8'hA5, 1'b0, 1'b0), 1'b1, 1'b1);
      tick();
      lookup1(32'h200);
      chk("t4_recover", 128'(pred_meta), 128'({90'b0, mk(10'h0CB, 10'h080, 8'h4B, 1'b0, 1'b0)}));
      tick();

      // Oldest mispredicting port wins, also while fetch is stalled: 11,nt -> 22.
      clr();
      fetch_stall = 1'b1;
      set_upd(0, mk(10'h300, 10'h300, 8'h11, 1'b0, 1'b0), 1'b0, 1'b1);
      set_upd(1, mk(10'h301, 10'h301, 8'hFF, 1'b0, 1'b0), 1'b1, 1'b1);
      tick();
      lookup1(32'h200);
      chk("t4_port_prio", 128'(pred_meta), 128'({90'b0, mk(10'h0A2, 10'h080, 8'h22, 1'b0, 1'b0)}));
      tick();

      // Test 5: both ports not-taken on gshare 0x40 (11) -> 01; one taken -> 10.
      clr();
      fetch_stall = 1'b1;
      set_upd(0, mk(10'h040, 10'h3F0, 8'h22, 1'b1, 1'b1), 1'b0, 1'b0);
      set_upd(1, mk(10'h040, 10'h3F1, 8'h22, 1'b1, 1'b1), 1'b0, 1'b0);
      tick();
      lookup1(32'h188);   // sidx 0x62 ^ ghr 0x22 = gshare 0x40
      chk("t5_two_ports", 128'(pred_meta), 128'({90'b0, mk(10'h040, 10'h062, 8'h22, 1'b0, 1'b0)}));
      tick();
      clr();
      fetch_stall = 1'b1;
      set_upd(0, mk(10'h040, 10'h3F2, 8'h22, 1'b0, 1'b0), 1'b1, 1'b0);
      tick();
      lookup1(32'h188);
      chk("t5_after_inc", 128'(pred_meta), 128'({90'b0, mk(10'h040, 10'h062, 8'h22, 1'b1, 1'b0)}));
      chk("t5_pred",      128'(pred_taken), 128'h0);
      tick();

      // Test 6: chooser at sidx 0x140: 01 -> 00, then gshare-correct resolves 00->01->10->11->11.
      clr();
      fetch_stall = 1'b1;
      set_upd(0, mk(10'h3E0, 10'h140, 8'h22, 1'b1, 1'b0), 1'b0, 1'b0);
      tick();
      clr();
      fetch_stall = 1'b1;
      set_upd(0, mk(10'h3E0, 10'h140, 8'h22, 1'b1, 1'b0), 1'b1, 1'b0);
      tick();
      tick();
      // chooser 10 selects gshare (0) over simple (10 -> 1)
      lookup1(32'h500);
      chk("t6_ch10_pred", 128'(pred_taken), 128'h0);
      chk("t6_ch10_meta", 128'(pred_meta), 128'({90'b0, mk(10'h162, 10'h140, 8'h22, 1'b0, 1'b1)}));
      clr();
      fetch_stall = 1'b1;
      set_upd(0, mk(10'h3E0, 10'h140, 8'h22, 1'b1, 1'b0), 1'b1, 1'b0);
      tick();
      lookup1(32'h500);
      chk("t6_ch11_pred", 128'(pred_taken), 128'h0);
      clr();
      fetch_stall = 1'b1;
      set_upd(0, mk(10'h3E0, 10'h140, 8'h22, 1'b1, 1'b0), 1'b1, 1'b0);
      tick();
      lookup1(32'h500);
      chk("t6_sat_pred", 128'(pred_taken), 128'h0);
      chk("t6_sat_meta", 128'(pred_meta), 128'({90'b0, mk(10'h162, 10'h140, 8'h22, 1'b0, 1'b1)}));
      tick();

`ifdef BP_STATS_EN
      exp_lk = 32'd3;
      exp_up = 32'd13;
      exp_mp = 32'd3;
`else
      exp_lk = 32'd0;
      exp_up = 32'd0;
      exp_mp = 32'd0;
`endif
      chk("stat_lookups",  128'(stat_lookups),  128'(exp_lk));
      chk("stat_updates",  128'(stat_updates),  128'(exp_up));
      chk("stat_mispreds", 128'(stat_mispreds), 128'(exp_mp));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
